// File: rtl/spi_bitrev_pkg.sv
// Shared types and helpers for the bit-reversing SPI test slave.
package spi_bitrev_pkg;

    // Widest word the helper function handles
    localparam int unsigned MAX_W = 32;

    // Protocol FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RX   = 2'b01,
        ST_TX   = 2'b10
    } state_e;

    // Reverse the low 'width' bits of 'word': r[i] = word[width-1-i]; upper bits are zero
    function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] word,
                                                input int unsigned      width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                r[5'(i)] = word[5'(width - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_bitrev_sync.sv
// Two-flop synchronisers for sck/ss/mosi plus sck edge detection.
// lead/trail are single-cycle pulses aligned with the synchronised mosi/ss.
module spi_bitrev_sync
    import spi_bitrev_pkg::*;
#(
    parameter bit CPOL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic ss_o,
    output logic mosi_o,
    output logic lead_o,
    output logic trail_o
);

    logic [1:0] sck_sync_q;
    logic [1:0] ss_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sck_prev_q;
    logic       sck_rise;
    logic       sck_fall;

    // Synchroniser chains; sck history resets to its idle level so no false edge follows reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= {2{CPOL}};
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            ss_sync_q   <= {ss_sync_q[0], ss_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    // Edge detection on the synchronised sck and mapping to leading/trailing roles
    always_comb begin
        sck_rise = sck_sync_q[1] & ~sck_prev_q;
        sck_fall = ~sck_sync_q[1] & sck_prev_q;
        lead_o   = CPOL ? sck_fall : sck_rise;
        trail_o  = CPOL ? sck_rise : sck_fall;
        ss_o     = ss_sync_q[1];
        mosi_o   = mosi_sync_q[1];
    end

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives a DATA_W-bit word and returns its bit-reversed
// image in the following DATA_W clocks, repeating while SS stays low.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          CPOL   = 1'b0,
    parameter bit          CPHA   = 1'b0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_done,
    output logic              abort
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic ss_s;
    logic mosi_s;
    logic lead;
    logic trail;

    spi_bitrev_sync #(
        .CPOL (CPOL)
    ) u_sync (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .sck_i   (sck),
        .ss_i    (ss),
        .mosi_i  (mosi),
        .ss_o    (ss_s),
        .mosi_o  (mosi_s),
        .lead_o  (lead),
        .trail_o (trail)
    );

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic              miso_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              tx_done_q;
    logic              abort_q;

    logic              sample_e;
    logic              shift_e;
    logic [CNT_W-1:0]  cnt_inc_d;
    logic [DATA_W-1:0] rx_word_d;
    logic [DATA_W-1:0] tx_load_d;

    // Edge roles per CPHA, next receive word and its reversed TX image
    always_comb begin
        sample_e  = CPHA ? trail : lead;
        shift_e   = CPHA ? lead  : trail;
        cnt_inc_d = cnt_q + CNT_W'(1);
        rx_word_d = {rx_sh_q[DATA_W-2:0], mosi_s};
        tx_load_d = DATA_W'(bitrev(MAX_W'(rx_word_d), DATA_W));
    end

    // Protocol FSM: SS high dominates, then sample/shift edge processing per state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            abort_q    <= 1'b0;
            if (ss_s) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                rx_sh_q <= '0;
                tx_sh_q <= '0;
                miso_q  <= 1'b1;
                abort_q <= (cnt_q != '0) || (state_q == ST_TX);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        miso_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_RX;
                    end
                    ST_RX: begin
                        // A shift edge here is the one following the last TX sample
                        if (shift_e) begin
                            miso_q <= 1'b1;
                        end
                        if (sample_e) begin
                            rx_sh_q <= rx_word_d;
                            if (cnt_q == CNT_LAST) begin
                                rx_data_q  <= rx_word_d;
                                rx_valid_q <= 1'b1;
                                tx_sh_q    <= tx_load_d;
                                cnt_q      <= '0;
                                state_q    <= ST_TX;
                            end else begin
                                cnt_q <= cnt_inc_d;
                            end
                        end
                    end
                    ST_TX: begin
                        if (shift_e) begin
                            miso_q  <= tx_sh_q[DATA_W-1];
                            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                        end
                        if (sample_e) begin
                            if (cnt_q == CNT_LAST) begin
                                tx_done_q <= 1'b1;
                                cnt_q     <= '0;
                                state_q   <= ST_RX;
                            end else begin
                                cnt_q <= cnt_inc_d;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        miso_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Only the three defined encodings may ever be reached
    a_state_legal: assert property (@(posedge clock) disable iff (!resetn)
        (state_q == ST_IDLE) || (state_q == ST_RX) || (state_q == ST_TX));

    // Registered outputs
    always_comb begin
        miso     = miso_q;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        tx_done  = tx_done_q;
        abort    = abort_q;
    end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench: three slaves (mode 0 / W8, mode 3 / W8, mode 1 / W16) on separate SPI buses.
module tb_spi_bitrev_slave;
    import spi_bitrev_pkg::*;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  sck;
    logic [2:0]  ss;
    logic [2:0]  mosi;
    logic [2:0]  miso_w;
    logic [2:0]  rxv;
    logic [2:0]  txd;
    logic [2:0]  abt;
    logic [7:0]  rxd0;
    logic [7:0]  rxd1;
    logic [15:0] rxd2;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int rxv_cnt[3] = '{default: 0};
    int txd_cnt[3] = '{default: 0};
    int abt_cnt[3] = '{default: 0};

    logic [31:0] rxq0[$];
    logic [31:0] rxq1[$];
    logic [31:0] rxq2[$];
    logic [31:0] txq[$];

    always #5 clock = ~clock;

    spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clock(clock), .resetn(resetn), .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]),
        .miso(miso_w[0]), .rx_data(rxd0), .rx_valid(rxv[0]), .tx_done(txd[0]), .abort(abt[0]));

    spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clock(clock), .resetn(resetn), .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]),
        .miso(miso_w[1]), .rx_data(rxd1), .rx_valid(rxv[1]), .tx_done(txd[1]), .abort(abt[1]));

    spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1)) dut2 (
        .clock(clock), .resetn(resetn), .sck(sck[2]), .ss(ss[2]), .mosi(mosi[2]),
        .miso(miso_w[2]), .rx_data(rxd2), .rx_valid(rxv[2]), .tx_done(txd[2]), .abort(abt[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input logic [1:0] k);
        return (k == 2'd2) ? 16 : 8;
    endfunction

    function automatic bit cpol_of(input logic [1:0] k);
        return k == 2'd1;
    endfunction

    function automatic bit cpha_of(input logic [1:0] k);
        return k != 2'd0;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_rx(input logic [1:0] k, input logic [31:0] v);
        case (k)
            2'd0:    rxq0.push_back(v);
            2'd1:    rxq1.push_back(v);
            default: rxq2.push_back(v);
        endcase
    endtask

    // Scoreboard side: every rx_valid pulse must match the oldest pending word
    task automatic sb_rx(input logic [1:0] k, input logic [31:0] got);
        int          pend;
        logic [31:0] e;
        e = '0;
        case (k)
            2'd0:    pend = rxq0.size();
            2'd1:    pend = rxq1.size();
            default: pend = rxq2.size();
        endcase
        check_eq("rx_pending", 32'(pend > 0), 32'd1);
        if (pend > 0) begin
            case (k)
                2'd0:    e = rxq0.pop_front();
                2'd1:    e = rxq1.pop_front();
                default: e = rxq2.pop_front();
            endcase
            check_eq("rx_data_sb", got, e);
        end
    endtask

    always @(negedge clock) begin
        if (rxv[0]) begin rxv_cnt[0]++; sb_rx(2'd0, 32'(rxd0)); end
        if (rxv[1]) begin rxv_cnt[1]++; sb_rx(2'd1, 32'(rxd1)); end
        if (rxv[2]) begin rxv_cnt[2]++; sb_rx(2'd2, 32'(rxd2)); end
        for (int i = 0; i < 3; i++) begin
            if (txd[i]) txd_cnt[i]++;
            if (abt[i]) abt_cnt[i]++;
        end
    end

    // Master: shift nbits of word (MSB first) and capture MISO at each sample edge
    task automatic spi_bits(input logic [1:0] k, input logic [31:0] word, input int nbits,
                            output logic [31:0] got);
        int   w;
        logic bv;
        w   = wid(k);
        got = '0;
        for (int b = 0; b < nbits; b++) begin
            bv = word[5'(w - 1 - b)];
            if (!cpha_of(k)) begin
                mosi[k] = bv;
                wait_clk(HALF);
                got = {got[30:0], miso_w[k]};
                sck[k] = ~cpol_of(k);
                wait_clk(HALF);
                sck[k] = cpol_of(k);
            end else begin
                sck[k] = ~cpol_of(k);
                mosi[k] = bv;
                wait_clk(HALF);
                got = {got[30:0], miso_w[k]};
                sck[k] = cpol_of(k);
                wait_clk(HALF);
            end
        end
    endtask

    task automatic ss_low(input logic [1:0] k);
        ss[k] = 1'b0;
        wait_clk(4);
    endtask

    task automatic ss_high(input logic [1:0] k);
        wait_clk(HALF);
        ss[k] = 1'b1;
        wait_clk(6);
    endtask

    // One RX frame then one TX frame; MISO is all ones during RX
    task automatic xfer_word(input logic [1:0] k, input logic [31:0] word,
                             input logic [31:0] exp_rev, input string tag);
        logic [31:0] got;
        logic [31:0] ones;
        ones = (32'd1 << wid(k)) - 32'd1;
        push_rx(k, word);
        txq.push_back(ones);
        txq.push_back(exp_rev);
        spi_bits(k, word, wid(k), got);
        check_eq({tag, "_miso_rx"}, got, txq.pop_front());
        spi_bits(k, '0, wid(k), got);
        check_eq({tag, "_miso_tx"}, got, txq.pop_front());
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        resetn = 1'b0;
        sck    = 3'b010;
        ss     = 3'b111;
        mosi   = 3'b000;
        wait_clk(3);
        check_eq("rst_miso", 32'(miso_w), 32'h7);
        check_eq("rst_rx_data", {rxd2, rxd1, rxd0}, 32'h0);
        check_eq("rst_pulses", 32'({rxv, txd, abt}), 32'h0);
        resetn = 1'b1;
        wait_clk(4);

        // Mode 0, 0xB4 -> 0x2D
        ss_low(2'd0);
        xfer_word(2'd0, 32'hB4, 32'h2D, "m0");
        ss_high(2'd0);
        check_eq("m0_rx_data", 32'(rxd0), 32'hB4);
        check_eq("m0_rxv_cnt", 32'(rxv_cnt[0]), 32'd1);
        check_eq("m0_txd_cnt", 32'(txd_cnt[0]), 32'd1);
        check_eq("m0_abt_cnt", 32'(abt_cnt[0]), 32'd0);

        // Mode 3, 0xF0 -> 0x0F
        ss_low(2'd1);
        xfer_word(2'd1, 32'hF0, 32'h0F, "m3");
        ss_high(2'd1);
        check_eq("m3_rx_data", 32'(rxd1), 32'hF0);
        check_eq("m3_rxv_cnt", 32'(rxv_cnt[1]), 32'd1);
        check_eq("m3_txd_cnt", 32'(txd_cnt[1]), 32'd1);
        check_eq("m3_abt_cnt", 32'(abt_cnt[1]), 32'd0);

        // Back-to-back frames in one SS assertion
        ss_low(2'd0);
        xfer_word(2'd0, 32'h01, 32'h80, "b2b_a");
        xfer_word(2'd0, 32'h80, 32'h01, "b2b_b");
        ss_high(2'd0);
        check_eq("b2b_rx_data", 32'(rxd0), 32'h80);
        check_eq("b2b_rxv_cnt", 32'(rxv_cnt[0]), 32'd3);
        check_eq("b2b_txd_cnt", 32'(txd_cnt[0]), 32'd3);
        check_eq("b2b_abt_cnt", 32'(abt_cnt[0]), 32'd0);

        // DATA_W=16, mode 1, 0x1234 -> 0x2C48
        ss_low(2'd2);
        xfer_word(2'd2, 32'h1234, 32'h2C48, "w16");
        ss_high(2'd2);
        check_eq("w16_rx_data", 32'(rxd2), 32'h1234);
        check_eq("w16_rxv_cnt", 32'(rxv_cnt[2]), 32'd1);
        check_eq("w16_txd_cnt", 32'(txd_cnt[2]), 32'd1);

        // SS raised after 5 RX bits
        ss_low(2'd0);
        spi_bits(2'd0, 32'hA5, 5, got);
        check_eq("abt_miso_rx", got, 32'h1F);
        ss_high(2'd0);
        check_eq("abt_cnt", 32'(abt_cnt[0]), 32'd1);
        check_eq("abt_state", 32'(dut0.state_q), 32'(ST_IDLE));
        check_eq("abt_miso", 32'(miso_w[0]), 32'd1);
        check_eq("abt_rxv_cnt", 32'(rxv_cnt[0]), 32'd3);
        check_eq("abt_rx_kept", 32'(rxd0), 32'h80);
        ss_low(2'd0);
        xfer_word(2'd0, 32'h3C, 32'h3C, "post_abt");
        ss_high(2'd0);
        check_eq("post_abt_rx_data", 32'(rxd0), 32'h3C);
        check_eq("post_abt_abt_cnt", 32'(abt_cnt[0]), 32'd1);

        // Reset during TX bit 4 (0x55 -> 0xAA; bit 4 of the reply is 0)
        ss_low(2'd0);
        push_rx(2'd0, 32'h55);
        spi_bits(2'd0, 32'h55, 8, got);
        check_eq("rst_mid_miso_rx", got, 32'hFF);
        spi_bits(2'd0, 32'h00, 3, got);
        check_eq("rst_mid_miso_tx3", got, 32'h5);
        wait_clk(4);
        check_eq("rst_mid_miso_pre", 32'(miso_w[0]), 32'd0);
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_miso", 32'(miso_w[0]), 32'd1);
        check_eq("rst_mid_rx_data", 32'(rxd0), 32'h0);
        ss[0] = 1'b1;
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(3);
        ss_low(2'd0);
        xfer_word(2'd0, 32'h01, 32'h80, "post_rst");
        ss_high(2'd0);
        check_eq("post_rst_rx_data", 32'(rxd0), 32'h01);
        check_eq("post_rst_rxv_cnt", 32'(rxv_cnt[0]), 32'd6);
        check_eq("post_rst_txd_cnt", 32'(txd_cnt[0]), 32'd5);
        check_eq("post_rst_abt_cnt", 32'(abt_cnt[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
